// File: rtl/wb_forward_source_pkg.sv
// Shared core definitions: datapath widths, register indices, opcodes and stage payloads.
package wb_forward_source_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 1 << ADDR_W;
    localparam int unsigned CNT_W    = 16;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_SHL = 4'h5,
        OP_SHR = 4'h6,
        OP_LDI = 4'h7,
        OP_LD  = 4'h8,
        OP_ST  = 4'h9,
        OP_BEQ = 4'hC,
        OP_JMP = 4'hD
    } opcode_e;

    // EX/MA boundary entry; data is the ALU result, stale for loads.
    typedef struct packed {
        logic              valid;
        logic              is_load;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } ma_entry_t;

    // MA/WB boundary entry; data is final write-back value.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // One-hot register select, all zero when the entry is not valid.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic valid, input logic [ADDR_W-1:0] rd);
        rd_onehot = valid ? (NUM_REGS'(1) << rd) : '0;
    endfunction

endpackage

// File: rtl/wb_forward_source_if.sv
// Pipeline-side bundle for the forwarding source: EX/ID inputs, RF write port, bypass outputs.
interface wb_forward_source_if;
    import wb_forward_source_pkg::*;

    logic                hold;
    logic                ex_valid;
    logic                ex_wr_en;
    logic                ex_is_load;
    logic [ADDR_W-1:0]   ex_rd;
    logic [DATA_W-1:0]   ex_alu_res;
    logic                ex_flush;
    logic [DATA_W-1:0]   ma_load_data;
    logic [ADDR_W-1:0]   id_rs;
    logic [ADDR_W-1:0]   id_rt;
    logic                id_uses_rt;

    logic                rf_we;
    logic [ADDR_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;
    logic                fwd_ma_valid;
    logic [ADDR_W-1:0]   fwd_ma_addr;
    logic [DATA_W-1:0]   fwd_ma_data;
    logic                fwd_ma_is_load;
    logic                fwd_wb_valid;
    logic [ADDR_W-1:0]   fwd_wb_addr;
    logic [DATA_W-1:0]   fwd_wb_data;
    logic [NUM_REGS-1:0] pending_mask;
    logic                load_use_stall;
    logic [CNT_W-1:0]    stall_count;

    modport master (
        output hold, ex_valid, ex_wr_en, ex_is_load, ex_rd, ex_alu_res, ex_flush,
               ma_load_data, id_rs, id_rt, id_uses_rt,
        input  rf_we, rf_waddr, rf_wdata,
               fwd_ma_valid, fwd_ma_addr, fwd_ma_data, fwd_ma_is_load,
               fwd_wb_valid, fwd_wb_addr, fwd_wb_data,
               pending_mask, load_use_stall, stall_count
    );

    modport slave (
        input  hold, ex_valid, ex_wr_en, ex_is_load, ex_rd, ex_alu_res, ex_flush,
               ma_load_data, id_rs, id_rt, id_uses_rt,
        output rf_we, rf_waddr, rf_wdata,
               fwd_ma_valid, fwd_ma_addr, fwd_ma_data, fwd_ma_is_load,
               fwd_wb_valid, fwd_wb_addr, fwd_wb_data,
               pending_mask, load_use_stall, stall_count
    );

endinterface

// File: rtl/wb_forward_source_stage_reg.sv
// Generic pipeline stage register: synchronous clear, frozen while hold is high.
module wb_forward_source_stage_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture the next entry unless the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/wb_forward_source.sv
// Forwarding producer: EX/MA and MA/WB stage registers, RF write port,
// bypass candidates, pending-write mask and load-use interlock.
module wb_forward_source
    import wb_forward_source_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    wb_forward_source_if.slave bus
);

    ma_entry_t           ma_d;
    ma_entry_t           ma_q;
    wb_entry_t           wb_d;
    wb_entry_t           wb_q;
    logic                load_use_c;
    logic [NUM_REGS-1:0] pending_c;
    logic [CNT_W-1:0]    stall_cnt_q;

    // Next MA/WB entries; writes to r0 and squashed instructions never become valid.
    always_comb begin
        ma_d         = '0;
        ma_d.valid   = bus.ex_valid & bus.ex_wr_en & ~bus.ex_flush & (bus.ex_rd != ZERO_REG);
        ma_d.is_load = bus.ex_is_load;
        ma_d.rd      = bus.ex_rd;
        ma_d.data    = bus.ex_alu_res;

        wb_d         = '0;
        wb_d.valid   = ma_q.valid;
        wb_d.rd      = ma_q.rd;
        wb_d.data    = ma_q.is_load ? bus.ma_load_data : ma_q.data;
    end

    wb_forward_source_stage_reg #(.W($bits(ma_entry_t))) u_ma_stage (
        .clk  (clk),
        .rst  (rst),
        .hold (bus.hold),
        .d    (ma_d),
        .q    (ma_q)
    );

    wb_forward_source_stage_reg #(.W($bits(wb_entry_t))) u_wb_stage (
        .clk  (clk),
        .rst  (rst),
        .hold (bus.hold),
        .d    (wb_d),
        .q    (wb_q)
    );

    // Load in EX feeding a source of the ID instruction; pending mask of in-flight writes.
    always_comb begin
        load_use_c = bus.ex_valid & bus.ex_is_load & bus.ex_wr_en & ~bus.ex_flush
                   & (bus.ex_rd != ZERO_REG)
                   & ((bus.ex_rd == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rd == bus.id_rt)));

        pending_c           = rd_onehot(ma_q.valid, ma_q.rd) | rd_onehot(wb_q.valid, wb_q.rd);
        pending_c[ZERO_REG] = 1'b0;
    end

    // Saturating count of interlock cycles that actually stall the front end.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (load_use_c && !bus.hold && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // A held WB entry is written exactly once, on the cycle hold drops.
    assign bus.rf_we          = wb_q.valid & ~bus.hold;
    assign bus.rf_waddr       = wb_q.rd;
    assign bus.rf_wdata       = wb_q.data;

    assign bus.fwd_ma_valid   = ma_q.valid;
    assign bus.fwd_ma_addr    = ma_q.rd;
    assign bus.fwd_ma_data    = ma_q.data;
    assign bus.fwd_ma_is_load = ma_q.is_load;

    assign bus.fwd_wb_valid   = wb_q.valid;
    assign bus.fwd_wb_addr    = wb_q.rd;
    assign bus.fwd_wb_data    = wb_q.data;

    assign bus.pending_mask   = pending_c;
    assign bus.load_use_stall = load_use_c;
    assign bus.stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_wb_forward_source.sv
// Directed bench for wb_forward_source: latency, loads, r0, flush, hold, reset, saturation.
module tb_wb_forward_source;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    wb_forward_source_if bus ();

    wb_forward_source dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle and sample 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle;
        #1;
    endtask

    task automatic idle;
        bus.hold         = 1'b0;
        bus.ex_valid     = 1'b0;
        bus.ex_wr_en     = 1'b0;
        bus.ex_is_load   = 1'b0;
        bus.ex_rd        = 3'd0;
        bus.ex_alu_res   = 16'h0000;
        bus.ex_flush     = 1'b0;
        bus.ma_load_data = 16'h0000;
        bus.id_rs        = 3'd0;
        bus.id_rt        = 3'd0;
        bus.id_uses_rt   = 1'b0;
    endtask

    task automatic drive_ex(input logic [2:0] rd, input logic [15:0] res, input logic is_load);
        bus.ex_valid   = 1'b1;
        bus.ex_wr_en   = 1'b1;
        bus.ex_is_load = is_load;
        bus.ex_rd      = rd;
        bus.ex_alu_res = res;
    endtask

    task automatic test_reset;
        idle();
        rst = 1'b1;
        tick();
        tick();
        settle();
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %0h want 0", bus.rf_we); end
        checks++; if (bus.fwd_ma_valid !== 1'b0 || bus.fwd_ma_addr !== 3'd0 || bus.fwd_ma_data !== 16'h0 || bus.fwd_ma_is_load !== 1'b0) begin
            errors++; $display("FAIL reset_fwd_ma: got v=%0h a=%0h d=%h l=%0h want all 0", bus.fwd_ma_valid, bus.fwd_ma_addr, bus.fwd_ma_data, bus.fwd_ma_is_load); end
        checks++; if (bus.fwd_wb_valid !== 1'b0 || bus.fwd_wb_addr !== 3'd0 || bus.fwd_wb_data !== 16'h0) begin
            errors++; $display("FAIL reset_fwd_wb: got v=%0h a=%0h d=%h want all 0", bus.fwd_wb_valid, bus.fwd_wb_addr, bus.fwd_wb_data); end
        checks++; if (bus.pending_mask !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h want 00", bus.pending_mask); end
        checks++; if (bus.stall_count !== 16'h0000) begin errors++; $display("FAIL reset_stall_count: got %h want 0000", bus.stall_count); end
        rst = 1'b0;
    endtask

    task automatic test_alu_forward;
        idle();
        drive_ex(3'd3, 16'h1234, 1'b0);
        tick();
        idle();
        settle();
        checks++; if (bus.fwd_ma_valid !== 1'b1 || bus.fwd_ma_addr !== 3'd3 || bus.fwd_ma_data !== 16'h1234 || bus.fwd_ma_is_load !== 1'b0) begin
            errors++; $display("FAIL alu_fwd_ma: got v=%0h a=%0h d=%h l=%0h want 1/3/1234/0", bus.fwd_ma_valid, bus.fwd_ma_addr, bus.fwd_ma_data, bus.fwd_ma_is_load); end
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL alu_rf_we_early: got %0h want 0", bus.rf_we); end
        checks++; if (bus.pending_mask !== 8'h08) begin errors++; $display("FAIL alu_pending_c1: got %h want 08", bus.pending_mask); end
        tick();
        settle();
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 3'd3 || bus.rf_wdata !== 16'h1234) begin
            errors++; $display("FAIL alu_rf_write: got we=%0h a=%0h d=%h want 1/3/1234", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        checks++; if (bus.fwd_wb_valid !== 1'b1 || bus.fwd_wb_addr !== 3'd3 || bus.fwd_wb_data !== 16'h1234) begin
            errors++; $display("FAIL alu_fwd_wb: got v=%0h a=%0h d=%h want 1/3/1234", bus.fwd_wb_valid, bus.fwd_wb_addr, bus.fwd_wb_data); end
        checks++; if (bus.fwd_ma_valid !== 1'b0) begin errors++; $display("FAIL alu_ma_drained: got %0h want 0", bus.fwd_ma_valid); end
        checks++; if (bus.pending_mask !== 8'h08) begin errors++; $display("FAIL alu_pending_c2: got %h want 08", bus.pending_mask); end
        tick();
        settle();
        checks++; if (bus.rf_we !== 1'b0 || bus.pending_mask !== 8'h00) begin
            errors++; $display("FAIL alu_retired: got we=%0h mask=%h want 0/00", bus.rf_we, bus.pending_mask); end
    endtask

    task automatic test_load_use;
        idle();
        drive_ex(3'd5, 16'h1111, 1'b1);
        bus.id_rs = 3'd2;
        bus.id_rt = 3'd5;
        settle();
        checks++; if (bus.load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_rt_unused: got %0h want 0", bus.load_use_stall); end
        bus.id_uses_rt = 1'b1;
        settle();
        checks++; if (bus.load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_rt_match: got %0h want 1", bus.load_use_stall); end
        bus.ex_flush = 1'b1;
        settle();
        checks++; if (bus.load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_flushed: got %0h want 0", bus.load_use_stall); end
        bus.ex_flush   = 1'b0;
        bus.id_uses_rt = 1'b0;
        bus.id_rs      = 3'd5;
        settle();
        checks++; if (bus.load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_rs_match: got %0h want 1", bus.load_use_stall); end
        tick();
        idle();
        bus.ma_load_data = 16'hBEEF;
        settle();
        checks++; if (bus.stall_count !== 16'd1) begin errors++; $display("FAIL lu_stall_count: got %h want 0001", bus.stall_count); end
        checks++; if (bus.fwd_ma_valid !== 1'b1 || bus.fwd_ma_is_load !== 1'b1 || bus.fwd_ma_addr !== 3'd5) begin
            errors++; $display("FAIL lu_fwd_ma: got v=%0h l=%0h a=%0h want 1/1/5", bus.fwd_ma_valid, bus.fwd_ma_is_load, bus.fwd_ma_addr); end
        tick();
        bus.ma_load_data = 16'h0000;
        settle();
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 3'd5 || bus.rf_wdata !== 16'hBEEF) begin
            errors++; $display("FAIL lu_rf_write: got we=%0h a=%0h d=%h want 1/5/BEEF", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        tick();
    endtask

    task automatic test_r0;
        idle();
        drive_ex(3'd0, 16'h5555, 1'b1);
        bus.id_rs = 3'd0;
        settle();
        checks++; if (bus.load_use_stall !== 1'b0) begin errors++; $display("FAIL r0_load_use: got %0h want 0", bus.load_use_stall); end
        tick();
        idle();
        settle();
        checks++; if (bus.fwd_ma_valid !== 1'b0 || bus.pending_mask !== 8'h00) begin
            errors++; $display("FAIL r0_ma: got v=%0h mask=%h want 0/00", bus.fwd_ma_valid, bus.pending_mask); end
        tick();
        settle();
        checks++; if (bus.rf_we !== 1'b0 || bus.fwd_wb_valid !== 1'b0) begin
            errors++; $display("FAIL r0_wb: got we=%0h v=%0h want 0/0", bus.rf_we, bus.fwd_wb_valid); end
        checks++; if (bus.stall_count !== 16'd1) begin errors++; $display("FAIL r0_stall_count: got %h want 0001", bus.stall_count); end
    endtask

    task automatic test_flush;
        idle();
        drive_ex(3'd6, 16'h0666, 1'b0);
        tick();
        drive_ex(3'd2, 16'h2222, 1'b0);
        bus.ex_flush = 1'b1;
        tick();
        idle();
        settle();
        checks++; if (bus.fwd_ma_valid !== 1'b0) begin errors++; $display("FAIL flush_ma_valid: got %0h want 0", bus.fwd_ma_valid); end
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 3'd6 || bus.rf_wdata !== 16'h0666) begin
            errors++; $display("FAIL flush_older_write: got we=%0h a=%0h d=%h want 1/6/0666", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        checks++; if (bus.pending_mask !== 8'h40) begin errors++; $display("FAIL flush_pending: got %h want 40", bus.pending_mask); end
        tick();
        settle();
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL flush_no_write: got %0h want 0", bus.rf_we); end
    endtask

    task automatic test_hold;
        int writes;
        writes = 0;
        idle();
        drive_ex(3'd4, 16'h00AA, 1'b0);
        tick();
        idle();
        tick();
        bus.hold = 1'b1;
        drive_ex(3'd7, 16'h7777, 1'b0);
        settle();
        for (int i = 0; i < 3; i++) begin
            if (bus.rf_we === 1'b1) writes++;
            checks++; if (bus.rf_we !== 1'b0 || bus.fwd_wb_valid !== 1'b1 || bus.fwd_wb_data !== 16'h00AA) begin
                errors++; $display("FAIL hold_frozen[%0d]: got we=%0h v=%0h d=%h want 0/1/00AA", i, bus.rf_we, bus.fwd_wb_valid, bus.fwd_wb_data); end
            checks++; if (bus.fwd_ma_valid !== 1'b0 || bus.pending_mask !== 8'h10) begin
                errors++; $display("FAIL hold_no_capture[%0d]: got v=%0h mask=%h want 0/10", i, bus.fwd_ma_valid, bus.pending_mask); end
            tick();
        end
        idle();
        settle();
        if (bus.rf_we === 1'b1) writes++;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 3'd4 || bus.rf_wdata !== 16'h00AA) begin
            errors++; $display("FAIL hold_release_write: got we=%0h a=%0h d=%h want 1/4/00AA", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        tick();
        settle();
        if (bus.rf_we === 1'b1) writes++;
        checks++; if (writes !== 1) begin errors++; $display("FAIL hold_write_count: got %0d want 1", writes); end
        checks++; if (bus.fwd_ma_valid !== 1'b0) begin errors++; $display("FAIL hold_r7_dropped: got %0h want 0", bus.fwd_ma_valid); end
    endtask

    task automatic test_reset_midflight;
        idle();
        drive_ex(3'd1, 16'h0101, 1'b0);
        tick();
        drive_ex(3'd2, 16'h0202, 1'b0);
        tick();
        idle();
        settle();
        checks++; if (bus.pending_mask !== 8'h06) begin errors++; $display("FAIL mid_pending_before: got %h want 06", bus.pending_mask); end
        rst = 1'b1;
        tick();
        settle();
        checks++; if (bus.rf_we !== 1'b0 || bus.fwd_ma_valid !== 1'b0 || bus.fwd_wb_valid !== 1'b0) begin
            errors++; $display("FAIL mid_valids: got we=%0h ma=%0h wb=%0h want 0/0/0", bus.rf_we, bus.fwd_ma_valid, bus.fwd_wb_valid); end
        checks++; if (bus.fwd_ma_data !== 16'h0 || bus.fwd_wb_data !== 16'h0 || bus.fwd_wb_addr !== 3'd0 || bus.pending_mask !== 8'h00) begin
            errors++; $display("FAIL mid_cleared: got mad=%h wbd=%h wba=%0h mask=%h want 0", bus.fwd_ma_data, bus.fwd_wb_data, bus.fwd_wb_addr, bus.pending_mask); end
        checks++; if (bus.stall_count !== 16'h0000) begin errors++; $display("FAIL mid_stall_count: got %h want 0000", bus.stall_count); end
        rst = 1'b0;
        tick();
        settle();
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL mid_no_write: got %0h want 0", bus.rf_we); end
    endtask

    task automatic test_saturation;
        idle();
        drive_ex(3'd5, 16'h0005, 1'b1);
        bus.id_rs = 3'd5;
        bus.hold  = 1'b1;
        settle();
        checks++; if (bus.load_use_stall !== 1'b1) begin errors++; $display("FAIL sat_lu_held: got %0h want 1", bus.load_use_stall); end
        tick();
        checks++; if (bus.stall_count !== 16'h0000) begin errors++; $display("FAIL sat_hold_no_count: got %h want 0000", bus.stall_count); end
        bus.hold = 1'b0;
        repeat (65534) tick();
        checks++; if (bus.stall_count !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h want FFFE", bus.stall_count); end
        tick();
        checks++; if (bus.stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h want FFFF", bus.stall_count); end
        repeat (3) tick();
        checks++; if (bus.stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold_max: got %h want FFFF", bus.stall_count); end
        idle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        idle();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_r0();
        test_flush();
        test_hold();
        test_reset_midflight();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_forward_source.md
# wb_forward_source

Producer side of the operand-forwarding path in the 16-bit pipelined core. Captures each retiring instruction's destination register and result at the EX/MA and MA/WB boundaries and drives the register-file write port. Publishes per-stage bypass candidates (valid, address, data) and a pending-write mask to the hazard unit. Generates the one-cycle load-use interlock.

## Interface
- DATA_W, 16, datapath width
- ADDR_W, 3, register address width (8 architectural registers, r0 hardwired zero)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- hold  in  1  global pipeline stall; freezes every stage register
- ex_valid  in  1  instruction in EX is real (not a bubble)
- ex_wr_en  in  1  EX instruction writes a register
- ex_is_load  in  1  EX instruction is a load (result arrives in MA)
- ex_rd  in  ADDR_W  EX destination register
- ex_alu_res  in  DATA_W  ALU result of EX instruction
- ex_flush  in  1  squash EX instruction (branch taken)
- ma_load_data  in  DATA_W  data-memory read data for the instruction in MA
- id_rs, id_rt  in  ADDR_W  source registers of the instruction in ID
- id_uses_rt  in  1  ID instruction reads id_rt
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- fwd_ma_valid, fwd_ma_addr, fwd_ma_data, fwd_ma_is_load  out  1/ADDR_W/DATA_W/1  MA-stage bypass candidate
- fwd_wb_valid, fwd_wb_addr, fwd_wb_data  out  1/ADDR_W/DATA_W  WB-stage bypass candidate
- pending_mask  out  2**ADDR_W  bit n set while a write to rn is in MA or WB
- load_use_stall  out  1  ID must stall one cycle
- stall_count  out  16  saturating count of cycles with load_use_stall high

## Operation
- Two stage registers: MA {valid, rd, data, is_load}, WB {valid, rd, data}.
- Capture into MA when hold=0: valid = ex_valid & ex_wr_en & ~ex_flush & (ex_rd != 0); rd = ex_rd; data = ex_alu_res; is_load = ex_is_load.
- Capture into WB when hold=0: valid/rd copied from MA; data = ma_load_data if MA.is_load else MA.data.
- rf_we = WB.valid & ~hold; rf_waddr/rf_wdata = WB.rd/WB.data. A held WB entry is written once, on the cycle hold drops.
- fwd_ma_data = MA.data; for loads it is not yet valid, so fwd_ma_is_load is exported and the hazard unit must not select it.
- fwd_wb_* mirror WB register directly.
- pending_mask = onehot(MA.rd) if MA.valid, OR onehot(WB.rd) if WB.valid; bit 0 always 0.
- load_use_stall (combinational) = ex_valid & ex_is_load & ex_wr_en & ~ex_flush & ex_rd != 0 & (ex_rd == id_rs | (id_uses_rt & ex_rd == id_rt)).
- stall_count increments on each cycle load_use_stall=1 and hold=0; saturates at 0xFFFF.
- Writes to r0 never enter the pipe, never forward, never assert rf_we.

## Timing
- Reset: all stage valids 0, rd/data 0, rf_we 0, all fwd_* 0, pending_mask 0, stall_count 0. load_use_stall follows its inputs (no state).
- Reset mid-operation discards in-flight writes; no rf_we until new instructions enter.
- Latency: instruction in EX at cycle N appears on fwd_ma at N+1, fwd_wb and rf_we at N+2 (no hold).
- hold extends each stage by exactly the held cycles; no entry lost or duplicated.
- ex_flush and hold together: flush wins only when capture occurs (hold=0); during hold the EX instruction is not captured.
- Same rd in MA and WB: both visible; hazard unit gives MA priority.

## Structure
- Shared core package: DATA_W, ADDR_W, opcode constants, zero-register index.
- One sub-module natural: fwd_stage_reg (valid/rd/data register with hold and reset), instantiated twice.

## Test plan
- ex_alu_res=0x1234, ex_rd=3, ex_wr_en=1 at cycle 0 -> fwd_ma valid addr 3 data 0x1234 cycle 1; rf_we addr 3 data 0x1234 cycle 2; pending_mask 0x08 cycles 1-2.
- Load to r5 in EX, id_rs=5 -> load_use_stall=1 same cycle; next cycle ma_load_data=0xBEEF -> rf_wdata 0xBEEF, stall_count=1.
- ex_rd=0, ex_wr_en=1 -> no fwd valid, pending_mask 0, rf_we never asserted.
- ex_flush=1 with ex_rd=2 -> MA.valid stays 0; older WB write proceeds unaffected.
- Write r4=0x00AA, hold=1 for 3 cycles once in WB -> rf_we low during hold, exactly one write of 0x00AA after release.
- rst asserted with valid entries in MA and WB -> next cycle all outputs 0, no rf_we; 65536 stall cycles -> stall_count holds 0xFFFF.
